// File: rtl/vector_seq_if.sv
// Control/data bundle between a test environment and vector_sequencer:
// vector memory write port, run handshake, DUT stimulus/response and results.
interface vector_seq_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 1,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [IN_W+OUT_W-1:0]   wr_data;
    logic [CW-1:0]           vec_count;
    logic                    start;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [CW-1:0]           err_count;
    logic [AW-1:0]           first_err_idx;
    logic                    first_err_valid;

    // Environment side: loads vectors, starts runs, returns the DUT response.
    modport master (
        output wr_en, wr_addr, wr_data, vec_count, start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err_idx, first_err_valid
    );

    // Sequencer side.
    modport slave (
        input  wr_en, wr_addr, wr_data, vec_count, start, dut_out,
        output dut_in, busy, done, pass, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/vector_sequencer.sv
// Clocked stimulus/check controller for small combinational blocks. Applies
// stored {inputs, expected} vectors one at a time, waits SETTLE cycles, then
// compares the DUT response and accumulates an error count.
module vector_sequencer #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    vector_seq_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = IN_W + OUT_W;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SettleLoad = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      n_q, n_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [IN_W-1:0]    dut_in_q, dut_in_d;
    logic [OUT_W-1:0]   exp_q, exp_d;
    logic [CW-1:0]      err_q, err_d;
    logic               pass_q, pass_d;
    logic [AW-1:0]      fei_q, fei_d;
    logic               fev_q, fev_d;

    logic [WW-1:0]      mem [DEPTH];

    logic               busy_w;
    logic               mismatch;
    logic               last_vec;
    logic [AW-1:0]      idx_next;
    logic [CW-1:0]      n_clamp;
    logic [CW-1:0]      err_sat_inc;
    logic [CW-1:0]      err_now;
    logic [WW-1:0]      word0;
    logic [WW-1:0]      word_next;

    assign busy_w      = (state_q == StApply) || (state_q == StWait) || (state_q == StCheck);
    // Case inequality so an X/Z response is always a failure in simulation.
    assign mismatch    = (bus.dut_out !== exp_q);
    assign idx_next    = idx_q + AW'(1);
    assign last_vec    = (CW'(idx_q) == (n_q - CW'(1)));
    assign n_clamp     = (bus.vec_count > DepthC) ? DepthC : bus.vec_count;
    assign err_sat_inc = (err_q == DepthC) ? err_q : (err_q + CW'(1));
    assign err_now     = mismatch ? err_sat_inc : err_q;
    assign word0       = mem[0];
    assign word_next   = mem[idx_next];

    // Vector memory write port; locked while a run is in progress. Not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_w) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            n_q      <= '0;
            settle_q <= '0;
            dut_in_q <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            fei_q    <= '0;
            fev_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            settle_q <= settle_d;
            dut_in_q <= dut_in_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            fei_q    <= fei_d;
            fev_q    <= fev_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        settle_d = settle_q;
        dut_in_d = dut_in_q;
        exp_d    = exp_q;
        err_d    = err_q;
        pass_d   = pass_q;
        fei_d    = fei_q;
        fev_d    = fev_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    n_d    = n_clamp;
                    idx_d  = '0;
                    err_d  = '0;
                    fei_d  = '0;
                    fev_d  = 1'b0;
                    pass_d = 1'b0;
                    if (n_clamp == '0) begin
                        // Empty run: nothing to check, trivially passes.
                        pass_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        dut_in_d = word0[WW-1:OUT_W];
                        exp_d    = word0[OUT_W-1:0];
                        state_d  = StApply;
                    end
                end
            end
            StApply: begin
                if (SETTLE > 0) begin
                    settle_d = SettleLoad;
                    state_d  = StWait;
                end else begin
                    state_d  = StCheck;
                end
            end
            StWait: begin
                if (settle_q == '0) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            StCheck: begin
                err_d = err_now;
                if (mismatch && !fev_q) begin
                    fei_d = idx_q;
                    fev_d = 1'b1;
                end
                if (last_vec) begin
                    pass_d  = (err_now == '0);
                    state_d = StDone;
                end else begin
                    idx_d    = idx_next;
                    dut_in_d = word_next[WW-1:OUT_W];
                    exp_d    = word_next[OUT_W-1:0];
                    state_d  = StApply;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.dut_in          = dut_in_q;
    assign bus.busy            = busy_w;
    assign bus.done            = (state_q == StDone);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_idx   = fei_q;
    assign bus.first_err_valid = fev_q;
endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: an xorfour model on a SETTLE=1 sequencer, plus a SETTLE=0
// sequencer whose DUT response is tied to X.
module tb_vector_sequencer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   bad;

    vector_seq_if #(.IN_W(4), .OUT_W(1), .DEPTH(16)) bus_a ();
    vector_seq_if #(.IN_W(4), .OUT_W(1), .DEPTH(16)) bus_b ();

    vector_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vector_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // xorfour behaviour for instance A; instance B sees an undriven-looking X.
    assign bus_a.dut_out = ^bus_a.dut_in;
    assign bus_b.dut_out = 1'bx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] xor_word(input int i, input bit flip);
        logic [3:0] a;
        a = i[3:0];
        return {a, (^a) ^ flip};
    endfunction

    task automatic write_a(input int addr, input logic [4:0] data);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = addr[3:0];
        bus_a.wr_data = data;
        step();
        bus_a.wr_en   = 1'b0;
    endtask

    // Start a run on A, count edges until done, and count stimulus samples
    // that differ from vector cyc/3. Optionally inject start+write at one cycle.
    task automatic run_a(input int vc, input int inject_at, output int cycles, output int nbad);
        cycles = 0;
        nbad   = 0;
        bus_a.vec_count = vc[4:0];
        bus_a.start     = 1'b1;
        step();
        bus_a.start     = 1'b0;
        while (bus_a.done !== 1'b1 && cycles < 200) begin
            if (cycles == inject_at) begin
                bus_a.start   = 1'b1;
                bus_a.wr_en   = 1'b1;
                bus_a.wr_addr = 4'd12;
                bus_a.wr_data = xor_word(12, 1'b1);
            end else if (cycles == inject_at + 1) begin
                bus_a.start = 1'b0;
                bus_a.wr_en = 1'b0;
            end
            if (cycles < 48 && bus_a.dut_in !== 4'(cycles / 3)) nbad++;
            step();
            cycles++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.vec_count = '0; bus_a.start = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.vec_count = '0; bus_b.start = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_pass", 32'(bus_a.pass), 32'd0);
        check("rst_err", 32'(bus_a.err_count), 32'd0);
        check("rst_dut_in", 32'(bus_a.dut_in), 32'd0);
        check("rst_fev", 32'(bus_a.first_err_valid), 32'd0);
        check("rst_fei", 32'(bus_a.first_err_idx), 32'd0);

        // xor4 truth table, full run.
        for (int i = 0; i < 16; i++) write_a(i, xor_word(i, 1'b0));
        run_a(16, -10, cyc, bad);
        check("xor_cycles", 32'(cyc), 32'd48);
        check("xor_seq", 32'(bad), 32'd0);
        check("xor_pass", 32'(bus_a.pass), 32'd1);
        check("xor_err", 32'(bus_a.err_count), 32'd0);
        check("xor_fev", 32'(bus_a.first_err_valid), 32'd0);
        check("xor_dut_in_hold", 32'(bus_a.dut_in), 32'd15);

        // Corrupted expectations at entries 5 and 9.
        write_a(5, xor_word(5, 1'b1));
        write_a(9, xor_word(9, 1'b1));
        run_a(16, -10, cyc, bad);
        check("bad_cycles", 32'(cyc), 32'd48);
        check("bad_err", 32'(bus_a.err_count), 32'd2);
        check("bad_fei", 32'(bus_a.first_err_idx), 32'd5);
        check("bad_fev", 32'(bus_a.first_err_valid), 32'd1);
        check("bad_pass", 32'(bus_a.pass), 32'd0);

        // Empty run.
        bus_a.vec_count = 5'd0;
        bus_a.start     = 1'b1;
        step();
        bus_a.start     = 1'b0;
        check("zero_done", 32'(bus_a.done), 32'd1);
        check("zero_pass", 32'(bus_a.pass), 32'd1);
        check("zero_busy", 32'(bus_a.busy), 32'd0);
        check("zero_err", 32'(bus_a.err_count), 32'd0);
        check("zero_dut_in", 32'(bus_a.dut_in), 32'd15);

        // Clamp 20 -> 16, with start and a corrupting write during WAIT of vector 3.
        write_a(5, xor_word(5, 1'b0));
        write_a(9, xor_word(9, 1'b0));
        run_a(20, 10, cyc, bad);
        check("clamp_cycles", 32'(cyc), 32'd48);
        check("clamp_seq", 32'(bad), 32'd0);
        check("clamp_err", 32'(bus_a.err_count), 32'd0);
        check("clamp_pass", 32'(bus_a.pass), 32'd1);

        // Reset during CHECK of vector 7, with one error already counted.
        write_a(2, xor_word(2, 1'b1));
        bus_a.vec_count = 5'd16;
        bus_a.start     = 1'b1;
        step();
        bus_a.start     = 1'b0;
        repeat (23) step();
        check("pre_rst_err", 32'(bus_a.err_count), 32'd1);
        check("pre_rst_dut_in", 32'(bus_a.dut_in), 32'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
        check("mid_rst_done", 32'(bus_a.done), 32'd0);
        check("mid_rst_err", 32'(bus_a.err_count), 32'd0);
        check("mid_rst_dut_in", 32'(bus_a.dut_in), 32'd0);
        run_a(16, -10, cyc, bad);
        check("rerun_cycles", 32'(cyc), 32'd48);
        check("rerun_seq", 32'(bad), 32'd0);
        check("rerun_err", 32'(bus_a.err_count), 32'd1);
        check("rerun_fei", 32'(bus_a.first_err_idx), 32'd2);
        check("rerun_pass", 32'(bus_a.pass), 32'd0);

        // SETTLE=0 instance, response X, all expectations 1.
        for (int i = 0; i < 4; i++) begin
            bus_b.wr_en   = 1'b1;
            bus_b.wr_addr = 4'(i);
            bus_b.wr_data = {4'(i), 1'b1};
            step();
        end
        bus_b.wr_en     = 1'b0;
        bus_b.vec_count = 5'd4;
        bus_b.start     = 1'b1;
        step();
        bus_b.start     = 1'b0;
        cyc = 0;
        while (bus_b.done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("x_cycles", 32'(cyc), 32'd8);
        check("x_err", 32'(bus_b.err_count), 32'd4);
        check("x_fei", 32'(bus_b.first_err_idx), 32'd0);
        check("x_fev", 32'(bus_b.first_err_valid), 32'd1);
        check("x_pass", 32'(bus_b.pass), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
